bit_alloc_sched: RTL and testbench

Stateful, parametrised successor to the combinational 64-bit first-set finder. It holds a WIDTH-entry bitmap and hands out one index per cycle through a registered take port. In ALLOC mode it is a lowest-index free-slot allocator (tags, buffer entries). In SCHEDULE mode it is a round-robin picker over pending entries (issue or wakeup queues). It sits between producers that set bits and one consumer that takes indices.

---
 rtl/bit_find_pkg.sv | 11 +
 rtl/bit_find_first.sv | 38 +++
 rtl/bit_alloc_sched.sv | 87 ++++++++
 tb/tb_bit_alloc_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_find_pkg.sv
// Shared constants and helpers for the bitmap allocator / round-robin scheduler.
package bit_find_pkg;

    localparam bit BF_MODE_ALLOC = 1'b1;
    localparam bit BF_MODE_SCHED = 1'b0;

    function automatic int unsigned bf_idxw(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_find_first.sv
// Combinational lowest-set-bit encoder, two-level: 8-bit groups, then a priority
// pick over group-any flags.
module bit_find_first
    import bit_find_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDXW  = bf_idxw(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [IDXW-1:0]  idx,
    output logic             hasany
);

    localparam int unsigned NG = WIDTH / 8;
    localparam int unsigned GW = (NG > 1) ? $clog2(NG) : 1;

    logic [NG-1:0] grp_any;
    logic [2:0]    grp_idx [NG];
    logic [GW-1:0] grp_sel;

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_any[g] = |bits[g*8 +: 8];
            grp_idx[g] = 3'd0;
            // Scan high to low so the lowest set bit wins.
            for (int b = 7; b >= 0; b--) begin
                if (bits[g*8 + b]) grp_idx[g] = 3'(b);
            end
        end
        grp_sel = '0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (grp_any[g]) grp_sel = GW'(g);
        end
        idx    = IDXW'({grp_sel, grp_idx[grp_sel]});
        hasany = |grp_any;
    end

endmodule

// File: rtl/bit_alloc_sched.sv
// Bitmap with a registered one-per-cycle take port: lowest-free allocator (ALLOC=1)
// or round-robin pending-entry picker (ALLOC=0).
module bit_alloc_sched
    import bit_find_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter bit          ALLOC = BF_MODE_ALLOC,
    parameter int unsigned IDXW  = bf_idxw(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [IDXW-1:0] set_idx,
    input  logic            take_req,
    output logic            take_vld,
    output logic [IDXW-1:0] take_idx,
    output logic [IDXW:0]   cnt,
    output logic            hasany,
    output logic            err
);

    localparam bit              IsAlloc = (ALLOC == BF_MODE_ALLOC);
    localparam logic [WIDTH-1:0] BitsRst = IsAlloc ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [IDXW:0]    CntRst  = IsAlloc ? (IDXW+1)'(WIDTH) : '0;

    logic [WIDTH-1:0] bits_q, bits_d, after_clr, search;
    logic [IDXW-1:0]  ptr_q, ptr_d, found, ff_idx, take_idx_q, take_idx_d;
    logic [IDXW:0]    cnt_q, cnt_d;
    logic             take_vld_q, hasany_q, err_q, err_d;
    logic             ff_any, grant, inc, dup;

    bit_find_first #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_find (
        .bits   (search),
        .idx    (ff_idx),
        .hasany (ff_any)
    );

    always_comb begin
        // Scheduler searches the bitmap rotated right by ptr, then un-rotates the index.
        search = IsAlloc ? bits_q : WIDTH'({bits_q, bits_q} >> ptr_q);
        found  = IsAlloc ? ff_idx : ff_idx + ptr_q;
        grant  = take_req & ff_any;

        after_clr = bits_q;
        if (grant) after_clr[found] = 1'b0;
        bits_d = after_clr;
        if (set_en) bits_d[set_idx] = 1'b1;

        inc   = set_en & ~after_clr[set_idx];
        dup   = set_en & after_clr[set_idx];
        err_d = err_q | dup;
        cnt_d = cnt_q - (IDXW+1)'(grant) + (IDXW+1)'(inc);

        ptr_d      = (!IsAlloc && grant) ? found + 1'b1 : ptr_q;
        take_idx_d = grant ? found : take_idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q     <= BitsRst;
            ptr_q      <= '0;
            take_vld_q <= 1'b0;
            take_idx_q <= '0;
            cnt_q      <= CntRst;
            hasany_q   <= IsAlloc;
            err_q      <= 1'b0;
        end else begin
            bits_q     <= bits_d;
            ptr_q      <= ptr_d;
            take_vld_q <= grant;
            take_idx_q <= take_idx_d;
            cnt_q      <= cnt_d;
            hasany_q   <= (cnt_d != '0);
            err_q      <= err_d;
        end
    end

    assign take_vld = take_vld_q;
    assign take_idx = take_idx_q;
    assign cnt      = cnt_q;
    assign hasany   = hasany_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bit_alloc_sched.sv
// Directed bench: allocator (64), scheduler (64) and allocator (128) instances.
module tb_bit_alloc_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Allocator, WIDTH=64
    logic       rst_a, set_en_a, take_req_a, take_vld_a, hasany_a, err_a;
    logic [5:0] set_idx_a, take_idx_a;
    logic [6:0] cnt_a;
    // Scheduler, WIDTH=64
    logic       rst_s, set_en_s, take_req_s, take_vld_s, hasany_s, err_s;
    logic [5:0] set_idx_s, take_idx_s;
    logic [6:0] cnt_s;
    // Allocator, WIDTH=128
    logic       rst_w, set_en_w, take_req_w, take_vld_w, hasany_w, err_w;
    logic [6:0] set_idx_w, take_idx_w;
    logic [7:0] cnt_w;

    bit_alloc_sched #(.WIDTH(64), .ALLOC(1'b1)) u_alloc (
        .clk(clk), .rst(rst_a), .set_en(set_en_a), .set_idx(set_idx_a),
        .take_req(take_req_a), .take_vld(take_vld_a), .take_idx(take_idx_a),
        .cnt(cnt_a), .hasany(hasany_a), .err(err_a)
    );

    bit_alloc_sched #(.WIDTH(64), .ALLOC(1'b0)) u_sched (
        .clk(clk), .rst(rst_s), .set_en(set_en_s), .set_idx(set_idx_s),
        .take_req(take_req_s), .take_vld(take_vld_s), .take_idx(take_idx_s),
        .cnt(cnt_s), .hasany(hasany_s), .err(err_s)
    );

    bit_alloc_sched #(.WIDTH(128), .ALLOC(1'b1)) u_wide (
        .clk(clk), .rst(rst_w), .set_en(set_en_w), .set_idx(set_idx_w),
        .take_req(take_req_w), .take_vld(take_vld_w), .take_idx(take_idx_w),
        .cnt(cnt_w), .hasany(hasany_w), .err(err_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a, hasany_a, err_a} !== {1'b0, 6'd0, 7'd64, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_alloc got vld=%0d idx=%0d cnt=%0d any=%0d err=%0d want 0 0 64 1 0",
                     take_vld_a, take_idx_a, cnt_a, hasany_a, err_a);
        end
        checks++;
        if ({take_vld_s, take_idx_s, cnt_s, hasany_s, err_s} !== {1'b0, 6'd0, 7'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_sched got vld=%0d idx=%0d cnt=%0d any=%0d err=%0d want 0 0 0 0 0",
                     take_vld_s, take_idx_s, cnt_s, hasany_s, err_s);
        end
        checks++;
        if ({take_vld_w, cnt_w, hasany_w} !== {1'b0, 8'd128, 1'b1}) begin
            errors++;
            $display("FAIL reset_wide got vld=%0d cnt=%0d any=%0d want 0 128 1",
                     take_vld_w, cnt_w, hasany_w);
        end
        rst_a = 1'b0;
        rst_s = 1'b0;
        rst_w = 1'b0;
    endtask

    task automatic test_alloc_first();
        take_req_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (take_vld_a !== 1'b1 || take_idx_a !== 6'(k)) begin
                errors++;
                $display("FAIL alloc_first got vld=%0d idx=%0d want 1 %0d", take_vld_a, take_idx_a, k);
            end
        end
        take_req_a = 1'b0;
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a, hasany_a} !== {1'b0, 6'd2, 7'd61, 1'b1}) begin
            errors++;
            $display("FAIL alloc_idle got vld=%0d idx=%0d cnt=%0d any=%0d want 0 2 61 1",
                     take_vld_a, take_idx_a, cnt_a, hasany_a);
        end
    endtask

    task automatic test_drain();
        take_req_a = 1'b1;
        for (int k = 3; k < 64; k++) begin
            tick();
            checks++;
            if (take_vld_a !== 1'b1 || take_idx_a !== 6'(k) || cnt_a !== 7'(63 - k)) begin
                errors++;
                $display("FAIL drain got vld=%0d idx=%0d cnt=%0d want 1 %0d %0d",
                         take_vld_a, take_idx_a, cnt_a, k, 63 - k);
            end
        end
        tick();
        checks++;
        if ({take_vld_a, cnt_a, hasany_a} !== {1'b0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL empty_take got vld=%0d cnt=%0d any=%0d want 0 0 0",
                     take_vld_a, cnt_a, hasany_a);
        end
        // Set and take together on an empty bitmap: the new bit is not visible yet.
        set_en_a  = 1'b1;
        set_idx_a = 6'd37;
        tick();
        checks++;
        if ({take_vld_a, cnt_a, hasany_a} !== {1'b0, 7'd1, 1'b1}) begin
            errors++;
            $display("FAIL bypass got vld=%0d cnt=%0d any=%0d want 0 1 1", take_vld_a, cnt_a, hasany_a);
        end
        set_en_a = 1'b0;
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a, hasany_a} !== {1'b1, 6'd37, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL refill_take got vld=%0d idx=%0d cnt=%0d any=%0d want 1 37 0 0",
                     take_vld_a, take_idx_a, cnt_a, hasany_a);
        end
        take_req_a = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle();
        set_en_a  = 1'b1;
        set_idx_a = 6'd4;
        tick();
        set_idx_a = 6'd10;
        tick();
        take_req_a = 1'b1;
        set_idx_a  = 6'd4;
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a, err_a} !== {1'b1, 6'd4, 7'd2, 1'b0}) begin
            errors++;
            $display("FAIL same_cycle got vld=%0d idx=%0d cnt=%0d err=%0d want 1 4 2 0",
                     take_vld_a, take_idx_a, cnt_a, err_a);
        end
        set_en_a = 1'b0;
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a} !== {1'b1, 6'd4, 7'd1}) begin
            errors++;
            $display("FAIL same_cycle_kept got vld=%0d idx=%0d cnt=%0d want 1 4 1",
                     take_vld_a, take_idx_a, cnt_a);
        end
        tick();
        checks++;
        if ({take_vld_a, take_idx_a, cnt_a, err_a} !== {1'b1, 6'd10, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL same_cycle_next got vld=%0d idx=%0d cnt=%0d err=%0d want 1 10 0 0",
                     take_vld_a, take_idx_a, cnt_a, err_a);
        end
        take_req_a = 1'b0;
        tick();
    endtask

    task automatic test_double_set();
        set_en_a  = 1'b1;
        set_idx_a = 6'd9;
        tick();
        checks++;
        if ({err_a, cnt_a} !== {1'b0, 7'd1}) begin
            errors++;
            $display("FAIL first_set got err=%0d cnt=%0d want 0 1", err_a, cnt_a);
        end
        tick();
        checks++;
        if ({err_a, cnt_a} !== {1'b1, 7'd1}) begin
            errors++;
            $display("FAIL double_set got err=%0d cnt=%0d want 1 1", err_a, cnt_a);
        end
        set_en_a = 1'b0;
        repeat (3) tick();
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got err=%0d want 1", err_a);
        end
        rst_a = 1'b1;
        #1;
        checks++;
        if ({err_a, cnt_a, hasany_a} !== {1'b0, 7'd64, 1'b1}) begin
            errors++;
            $display("FAIL err_reset got err=%0d cnt=%0d any=%0d want 0 64 1", err_a, cnt_a, hasany_a);
        end
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_sched();
        logic [5:0] exp_idx [5];
        exp_idx[0] = 6'd5;  exp_idx[1] = 6'd20; exp_idx[2] = 6'd60;
        exp_idx[3] = 6'd63; exp_idx[4] = 6'd5;
        set_en_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_idx_s = exp_idx[k];
            tick();
        end
        set_en_s = 1'b0;
        checks++;
        if ({cnt_s, hasany_s, err_s} !== {7'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sched_fill got cnt=%0d any=%0d err=%0d want 3 1 0", cnt_s, hasany_s, err_s);
        end
        take_req_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (take_vld_s !== 1'b1 || take_idx_s !== exp_idx[k] || cnt_s !== 7'(2 - k)) begin
                errors++;
                $display("FAIL sched_grant got vld=%0d idx=%0d cnt=%0d want 1 %0d %0d",
                         take_vld_s, take_idx_s, cnt_s, exp_idx[k], 2 - k);
            end
        end
        tick();
        checks++;
        if ({take_vld_s, take_idx_s, hasany_s} !== {1'b0, 6'd60, 1'b0}) begin
            errors++;
            $display("FAIL sched_empty got vld=%0d idx=%0d any=%0d want 0 60 0",
                     take_vld_s, take_idx_s, hasany_s);
        end
        take_req_s = 1'b0;
        set_en_s   = 1'b1;
        set_idx_s  = 6'd5;
        tick();
        set_idx_s = 6'd63;
        tick();
        set_en_s   = 1'b0;
        take_req_s = 1'b1;
        for (int k = 3; k < 5; k++) begin
            tick();
            checks++;
            if (take_vld_s !== 1'b1 || take_idx_s !== exp_idx[k]) begin
                errors++;
                $display("FAIL sched_wrap got vld=%0d idx=%0d want 1 %0d",
                         take_vld_s, take_idx_s, exp_idx[k]);
            end
        end
        take_req_s = 1'b0;
        tick();
        checks++;
        if ({take_vld_s, cnt_s, err_s} !== {1'b0, 7'd0, 1'b0}) begin
            errors++;
            $display("FAIL sched_done got vld=%0d cnt=%0d err=%0d want 0 0 0", take_vld_s, cnt_s, err_s);
        end
    endtask

    task automatic test_reset_mid();
        take_req_w = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (take_vld_w !== 1'b1 || take_idx_w !== 7'(k)) begin
                errors++;
                $display("FAIL wide_take got vld=%0d idx=%0d want 1 %0d", take_vld_w, take_idx_w, k);
            end
        end
        #2;
        rst_w = 1'b1;
        #1;
        checks++;
        if ({take_vld_w, take_idx_w, cnt_w, hasany_w, err_w} !== {1'b0, 7'd0, 8'd128, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got vld=%0d idx=%0d cnt=%0d any=%0d err=%0d want 0 0 128 1 0",
                     take_vld_w, take_idx_w, cnt_w, hasany_w, err_w);
        end
        tick();
        rst_w = 1'b0;
        tick();
        checks++;
        if ({take_vld_w, take_idx_w, cnt_w} !== {1'b1, 7'd0, 8'd127}) begin
            errors++;
            $display("FAIL post_reset_take got vld=%0d idx=%0d cnt=%0d want 1 0 127",
                     take_vld_w, take_idx_w, cnt_w);
        end
        take_req_w = 1'b0;
        tick();
    endtask

    initial begin
        rst_a = 1'b0; rst_s = 1'b0; rst_w = 1'b0;
        set_en_a = 1'b0; set_idx_a = '0; take_req_a = 1'b0;
        set_en_s = 1'b0; set_idx_s = '0; take_req_s = 1'b0;
        set_en_w = 1'b0; set_idx_w = '0; take_req_w = 1'b0;
        #2;
        rst_a = 1'b1; rst_s = 1'b1; rst_w = 1'b1;
        test_reset();
        test_alloc_first();
        test_drain();
        test_same_cycle();
        test_double_set();
        test_sched();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
